// File: rtl/bd_tag_merge_pkg.sv
// Shared constants and types for the BD tag merge/split pair: leaf codes,
// field widths and the round-robin grant encoding.
package BDTagMergePkg;

    localparam int NBDpayload = 32;
    localparam int NBDcode    = 4;
    localparam int Ntag       = 11;
    localparam int Nct        = 9;

    // Leaf codes shared with the splitter.
    localparam logic [NBDcode-1:0] RO_ACC_code     = 4'd0;
    localparam logic [NBDcode-1:0] RO_TAT_code     = 4'd1;
    localparam logic [NBDcode-1:0] INPUT_TAGS_code = 4'd2;

    typedef enum logic {
        GRANT_TAG   = 1'b0,
        GRANT_OTHER = 1'b1
    } grant_e;

endpackage

// File: rtl/bd_tag_merge_rr_arb.sv
// Two-input round-robin arbiter; last_grant moves only when the granted
// request is actually transferred (room high).
module bd_tag_merge_rr_arb
    import BDTagMergePkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   req_tag,
    input  logic   req_other,
    input  logic   room,
    output grant_e grant
);

    grant_e last_grant_q;
    grant_e last_grant_d;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        grant        = GRANT_TAG;
        last_grant_d = last_grant_q;
        if (req_tag && req_other) begin
            grant = (last_grant_q == GRANT_TAG) ? GRANT_OTHER : GRANT_TAG;
        end else if (req_other) begin
            grant = GRANT_OTHER;
        end
        if ((req_tag || req_other) && room) begin
            last_grant_d = grant;
        end
    end

    // OTHER at reset so the tag stream wins the first contention.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_OTHER;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/bd_tag_merge.sv
// Merges packed tag/count words and decoded BD words into one registered BD
// word stream. Emitted-word counters are built only with BD_TAG_MERGE_COUNT_EN.
module bd_tag_merge #(
    parameter int NBDpayload      = BDTagMergePkg::NBDpayload,
    parameter int NBDcode         = BDTagMergePkg::NBDcode,
    parameter int Ntag            = BDTagMergePkg::Ntag,
    parameter int Nct             = BDTagMergePkg::Nct,
    parameter int INPUT_TAGS_code = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    // tag_in channel (sink)
    input  logic [Ntag-1:0]              tag_in_tag,
    input  logic [Nct-1:0]               tag_in_ct,
    input  logic                         tag_in_v,
    output logic                         tag_in_a,
    // other_in channel (sink)
    input  logic [NBDpayload-1:0]        other_in_payload,
    input  logic [NBDcode-1:0]           other_in_leaf_code,
    input  logic                         other_in_v,
    output logic                         other_in_a,
    // BD_out channel (source)
    output logic [NBDpayload-1:0]        BD_out_payload,
    output logic [NBDcode-1:0]           BD_out_leaf_code,
    output logic                         BD_out_v,
    input  logic                         BD_out_a,
    // TagMergeConf
    input  logic [NBDpayload-Ntag-Nct-1:0] conf_global_tag,
    output logic [31:0]                  n_tag_sent,
    output logic [31:0]                  n_other_sent
);

    logic                    out_v_q, out_v_d;
    logic [NBDpayload-1:0]   out_payload_q, out_payload_d;
    logic [NBDcode-1:0]      out_leaf_code_q, out_leaf_code_d;
    logic                    room;
    logic                    tag_fire, other_fire;
    logic                    load_tag, load_other;
    BDTagMergePkg::grant_e   grant;

    // Reset gates room so nothing is acked while the register is being cleared.
    assign room = (~out_v_q | BD_out_a) & ~reset;

    bd_tag_merge_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_tag   (tag_in_v),
        .req_other (other_in_v),
        .room      (room),
        .grant     (grant)
    );

    assign tag_in_a   = tag_in_v   && (grant == BDTagMergePkg::GRANT_TAG)   && room;
    assign other_in_a = other_in_v && (grant == BDTagMergePkg::GRANT_OTHER) && room;

    assign tag_fire   = tag_in_v & tag_in_a;
    assign other_fire = other_in_v & other_in_a;
    // Zero-count tags are consumed but never reach the output register.
    assign load_tag   = tag_fire && (tag_in_ct != '0);
    assign load_other = other_fire;

    always_comb begin
        out_v_d         = out_v_q;
        out_payload_d   = out_payload_q;
        out_leaf_code_d = out_leaf_code_q;
        if (load_tag) begin
            out_v_d         = 1'b1;
            out_payload_d   = {conf_global_tag, tag_in_tag, tag_in_ct};
            out_leaf_code_d = NBDcode'(INPUT_TAGS_code);
        end else if (load_other) begin
            out_v_d         = 1'b1;
            out_payload_d   = other_in_payload;
            out_leaf_code_d = other_in_leaf_code;
        end else if (BD_out_a) begin
            out_v_d         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_v_q         <= 1'b0;
            out_payload_q   <= '0;
            out_leaf_code_q <= '0;
        end else begin
            out_v_q         <= out_v_d;
            out_payload_q   <= out_payload_d;
            out_leaf_code_q <= out_leaf_code_d;
        end
    end

    assign BD_out_v         = out_v_q;
    assign BD_out_payload   = out_payload_q;
    assign BD_out_leaf_code = out_leaf_code_q;

`ifdef BD_TAG_MERGE_COUNT_EN
    logic [31:0] n_tag_q;
    logic [31:0] n_other_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            n_tag_q   <= '0;
            n_other_q <= '0;
        end else begin
            if (load_tag && (n_tag_q != '1)) begin
                n_tag_q <= n_tag_q + 32'd1;
            end
            if (load_other && (n_other_q != '1)) begin
                n_other_q <= n_other_q + 32'd1;
            end
        end
    end

    assign n_tag_sent   = n_tag_q;
    assign n_other_sent = n_other_q;
`else
    assign n_tag_sent   = '0;
    assign n_other_sent = '0;
`endif

endmodule

// File: tb/tb_bd_tag_merge.sv
// Directed bench for bd_tag_merge: a cycle-by-cycle vector table plus
// hand-written contention and reset sequences.
module tb_bd_tag_merge;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] tag_in_tag;
    logic [8:0]  tag_in_ct;
    logic        tag_in_v;
    logic        tag_in_a;
    logic [31:0] other_in_payload;
    logic [3:0]  other_in_leaf_code;
    logic        other_in_v;
    logic        other_in_a;
    logic [31:0] BD_out_payload;
    logic [3:0]  BD_out_leaf_code;
    logic        BD_out_v;
    logic        BD_out_a;
    logic [11:0] conf_global_tag;
    logic [31:0] n_tag_sent;
    logic [31:0] n_other_sent;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bd_tag_merge dut (
        .clk                (clk),
        .reset              (reset),
        .tag_in_tag         (tag_in_tag),
        .tag_in_ct          (tag_in_ct),
        .tag_in_v           (tag_in_v),
        .tag_in_a           (tag_in_a),
        .other_in_payload   (other_in_payload),
        .other_in_leaf_code (other_in_leaf_code),
        .other_in_v         (other_in_v),
        .other_in_a         (other_in_a),
        .BD_out_payload     (BD_out_payload),
        .BD_out_leaf_code   (BD_out_leaf_code),
        .BD_out_v           (BD_out_v),
        .BD_out_a           (BD_out_a),
        .conf_global_tag    (conf_global_tag),
        .n_tag_sent         (n_tag_sent),
        .n_other_sent       (n_other_sent)
    );

    typedef struct {
        logic        tv;
        logic [10:0] tag;
        logic [8:0]  ct;
        logic        ov;
        logic [31:0] op;
        logic [3:0]  ol;
        logic        ba;
        logic        e_ta;
        logic        e_oa;
        logic        e_v;
        logic [31:0] e_p;
        logic [3:0]  e_l;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tag_word(input logic [10:0] t, input logic [8:0] c);
        return {12'h005, t, c};
    endfunction

    initial begin
        logic        ta_s, oa_s;
        logic [31:0] prev_p;
        logic [3:0]  prev_l;
        int          ti, oi;

        // Cycle-by-cycle table starting from the reset state (global_tag = 5).
        vecs[0]  = '{1'b1, 11'h123, 9'h007, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0};
        vecs[1]  = '{1'b0, 11'h000, 9'h000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00524607, 4'h2};
        vecs[2]  = '{1'b1, 11'h001, 9'h001, 1'b1, 32'hDEADBEEF, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00524607, 4'h2};
        vecs[3]  = '{1'b1, 11'h001, 9'h001, 1'b1, 32'hCAFE0001, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 4'h9};
        vecs[4]  = '{1'b0, 11'h000, 9'h000, 1'b1, 32'hCAFE0001, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00500201, 4'h2};
        vecs[5]  = '{1'b0, 11'h000, 9'h000, 1'b1, 32'hCAFE0001, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00500201, 4'h2};
        vecs[6]  = '{1'b0, 11'h000, 9'h000, 1'b1, 32'hCAFE0001, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00500201, 4'h2};
        vecs[7]  = '{1'b1, 11'h7FF, 9'h000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFE0001, 4'hA};
        vecs[8]  = '{1'b1, 11'h002, 9'h003, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hCAFE0001, 4'hA};
        vecs[9]  = '{1'b0, 11'h000, 9'h000, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00500403, 4'h2};
        vecs[10] = '{1'b0, 11'h000, 9'h000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00500403, 4'h2};
        vecs[11] = '{1'b0, 11'h000, 9'h000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00500403, 4'h2};

        reset              = 1'b1;
        tag_in_tag         = '0;
        tag_in_ct          = '0;
        tag_in_v           = 1'b0;
        other_in_payload   = '0;
        other_in_leaf_code = '0;
        other_in_v         = 1'b0;
        BD_out_a           = 1'b0;
        conf_global_tag    = 12'h005;
        repeat (2) next_cycle();
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            tag_in_v           = vecs[i].tv;
            tag_in_tag         = vecs[i].tag;
            tag_in_ct          = vecs[i].ct;
            other_in_v         = vecs[i].ov;
            other_in_payload   = vecs[i].op;
            other_in_leaf_code = vecs[i].ol;
            BD_out_a           = vecs[i].ba;
            @(negedge clk);
            check($sformatf("vec%0d tag_a", i),   32'(tag_in_a),         32'(vecs[i].e_ta));
            check($sformatf("vec%0d other_a", i), 32'(other_in_a),       32'(vecs[i].e_oa));
            check($sformatf("vec%0d out_v", i),   32'(BD_out_v),         32'(vecs[i].e_v));
            check($sformatf("vec%0d payload", i), BD_out_payload,        vecs[i].e_p);
            check($sformatf("vec%0d leaf", i),    32'(BD_out_leaf_code), 32'(vecs[i].e_l));
            next_cycle();
        end

`ifdef BD_TAG_MERGE_COUNT_EN
        check("n_tag_sent table",   n_tag_sent,   32'd3);
        check("n_other_sent table", n_other_sent, 32'd2);
`else
        check("n_tag_sent tied",   n_tag_sent,   32'd0);
        check("n_other_sent tied", n_other_sent, 32'd0);
`endif

        // Continuous dual contention after a fresh reset: TAG, OTHER, TAG, ...
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        ti = 0;
        oi = 0;
        prev_p = '0;
        prev_l = '0;
        for (int k = 0; k < 10; k++) begin
            tag_in_v           = 1'b1;
            tag_in_tag         = 11'(11'h010 + ti);
            tag_in_ct          = 9'(ti + 1);
            other_in_v         = 1'b1;
            other_in_payload   = 32'hA0000000 + 32'(oi);
            other_in_leaf_code = 4'h7;
            BD_out_a           = 1'b1;
            @(negedge clk);
            ta_s = tag_in_a;
            oa_s = other_in_a;
            check($sformatf("rr%0d tag_a", k),   32'(ta_s), 32'((k % 2) == 0));
            check($sformatf("rr%0d other_a", k), 32'(oa_s), 32'((k % 2) == 1));
            if (k > 0) begin
                check($sformatf("rr%0d out_v", k),   32'(BD_out_v),         32'd1);
                check($sformatf("rr%0d payload", k), BD_out_payload,        prev_p);
                check($sformatf("rr%0d leaf", k),    32'(BD_out_leaf_code), 32'(prev_l));
            end
            if ((k % 2) == 0) begin
                prev_p = tag_word(11'(11'h010 + ti), 9'(ti + 1));
                prev_l = 4'h2;
            end else begin
                prev_p = 32'hA0000000 + 32'(oi);
                prev_l = 4'h7;
            end
            next_cycle();
            if (ta_s) ti++;
            if (oa_s) oi++;
        end

        // Reset while the register is full and both sources are valid.
        reset = 1'b1;
        @(negedge clk);
        check("rst tag_a",   32'(tag_in_a),   32'd0);
        check("rst other_a", 32'(other_in_a), 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("post-rst out_v",   32'(BD_out_v),   32'd0);
        check("post-rst tag_a",   32'(tag_in_a),   32'd1);
        check("post-rst other_a", 32'(other_in_a), 32'd0);
        check("post-rst n_tag",   n_tag_sent,      32'd0);
        check("post-rst n_other", n_other_sent,    32'd0);
        next_cycle();
        tag_in_v   = 1'b0;
        other_in_v = 1'b0;
        @(negedge clk);
        check("post-rst word", BD_out_payload, tag_word(11'(11'h010 + ti), 9'(ti + 1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
